// File: rtl/switch_debounce.sv
// Purpose: two-flop synchronise and debounce each raw switch bit into a clean level, plus edge pulses and a settled flag.
// Latency: a held input change reaches x_out, rise/fall and changed on edge STABLE_CYCLES+1 after its first sampling edge.
// Backpressure: none; free-running every cycle, outputs are levels or one-cycle pulses with no handshake.
module switch_debounce #(
  parameter int WIDTH         = 8,
  parameter int CNT_W         = 20,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             settled
);

  localparam longint MAX_STABLE = (longint'(1) << CNT_W) - 1;

  // Reject thresholds the counter cannot represent at elaboration time.
  if ((longint'(STABLE_CYCLES) < 1) || (longint'(STABLE_CYCLES) > MAX_STABLE)) begin : g_bad_stable
    $error("switch_debounce: STABLE_CYCLES out of range for CNT_W");
  end

  // Terminal count: a mismatch seen while the counter holds this value commits.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } ch_state_t;

  logic [WIDTH-1:0]            s1;
  logic [WIDTH-1:0]            s2;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  ch_state_t                   state_q [WIDTH];
  ch_state_t                   state_d [WIDTH];
  logic [WIDTH-1:0]            x_d;
  logic [WIDTH-1:0]            rise_d;
  logic [WIDTH-1:0]            fall_d;
  logic                        settled_c;

  // Two-flop synchroniser; only s2 is trusted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  // Per-channel debounce state, counters, debounced level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '{default: IDLE};
      cnt_q   <= '0;
      x_out   <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_out   <= x_d;
      rise    <= rise_d;
      fall    <= fall_d;
      changed <= |(rise_d | fall_d);
    end
  end

  // Next-state: a match drops back to IDLE (glitch rejected); a mismatch
  // counts up and commits on the terminal count. With STABLE_CYCLES=1 the
  // first mismatch from IDLE commits directly.
  always_comb begin
    cnt_d  = cnt_q;
    x_d    = x_out;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          if (s2[i] != x_out[i]) begin
            if (cnt_q[i] == LAST) begin
              x_d[i]    = s2[i];
              rise_d[i] = s2[i];
              fall_d[i] = ~s2[i];
              cnt_d[i]  = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + 1'b1;
              state_d[i] = PENDING;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
        PENDING: begin
          if (s2[i] == x_out[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = IDLE;
          end else if (cnt_q[i] == LAST) begin
            x_d[i]     = s2[i];
            rise_d[i]  = s2[i];
            fall_d[i]  = ~s2[i];
            cnt_d[i]   = '0;
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // Settled when no channel has a pending count; built from registers only.
  always_comb begin
    settled_c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_q[i] != '0) settled_c = 1'b0;
    end
  end

  assign settled = settled_c;

endmodule
